uart_text_writer: RTL and testbench

Consumes the received-byte stream of the UART receiver (`o_wr`/`o_data`) and turns it into write cycles on the VGA character buffer. Maintains a text cursor and interprets a small set of ASCII control codes. Clears the new line on wrap and the whole screen on form feed, so the display shows a simple wrapping terminal. Sits between the UART receiver and the write port of the text RAM read by the VGA pixel pipeline.

---
 rtl/uart_text_writer.sv | 164 ++++++++++++++++
 tb/tb_uart_text_writer.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_text_writer.sv
// UART byte stream to character-RAM writer: keeps a text cursor, interprets
// CR/LF/BS/FF, and clears the new row on wrap and the whole screen on form feed.
module uart_text_writer #(
  parameter int COLS   = 80,
  parameter int ROWS   = 30,
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_wr,
  input  logic [7:0]        i_data,
  output logic              o_we,
  output logic [ADDR_W-1:0] o_addr,
  output logic [7:0]        o_char,
  output logic              o_busy,
  output logic              o_overrun
);

  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam logic [CW-1:0]     COL_MAX = CW'(COLS - 1);
  localparam logic [RW-1:0]     ROW_MAX = RW'(ROWS - 1);
  localparam logic [ADDR_W-1:0] COLS_A  = ADDR_W'(COLS);
  localparam logic [ADDR_W-1:0] ROWL_A  = ADDR_W'(COLS - 1);
  localparam logic [ADDR_W-1:0] LAST_A  = ADDR_W'(COLS * ROWS - 1);

  typedef enum logic [1:0] {IDLE, PUT, CLR_ROW, CLR_ALL} state_t;

  state_t            state_q;
  logic              wr_q;
  logic              pend_v_q;
  logic [7:0]        pend_q;
  logic [7:0]        put_char_q;
  logic              put_adv_q;
  logic [CW-1:0]     col_q;
  logic [RW-1:0]     row_q;
  logic [ADDR_W-1:0] clr_q;

  logic              rise, take, drop;
  logic [RW-1:0]     row_d;
  logic [ADDR_W-1:0] cur_addr, row_base;

  always_comb begin
    rise     = i_wr & ~wr_q;
    take     = (state_q == IDLE) & pend_v_q;
    // A byte landing on the same edge the FSM takes the pending one is kept.
    drop     = rise & pend_v_q & ~take;
    row_d    = (row_q == ROW_MAX) ? '0 : row_q + RW'(1);
    row_base = ADDR_W'(row_q) * COLS_A;
    cur_addr = row_base + ADDR_W'(col_q);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      wr_q       <= 1'b1;
      pend_v_q   <= 1'b0;
      pend_q     <= '0;
      put_char_q <= '0;
      put_adv_q  <= 1'b0;
      col_q      <= '0;
      row_q      <= '0;
      clr_q      <= '0;
      o_we       <= 1'b0;
      o_addr     <= '0;
      o_char     <= '0;
      o_busy     <= 1'b0;
      o_overrun  <= 1'b0;
    end else begin
      wr_q      <= i_wr;
      o_overrun <= drop;
      o_we      <= 1'b0;
      o_busy    <= 1'b0;

      if (rise && !drop) begin
        pend_q   <= i_data;
        pend_v_q <= 1'b1;
      end else if (take) begin
        pend_v_q <= 1'b0;
      end

      unique case (state_q)
        IDLE: begin
          if (pend_v_q) begin
            if (pend_q >= 8'h20 && pend_q <= 8'h7E) begin
              put_char_q <= pend_q;
              put_adv_q  <= 1'b1;
              state_q    <= PUT;
              o_busy     <= 1'b1;
            end else begin
              case (pend_q)
                8'h0D: col_q <= '0;
                8'h0A: begin
                  col_q   <= '0;
                  row_q   <= row_d;
                  clr_q   <= '0;
                  state_q <= CLR_ROW;
                  o_busy  <= 1'b1;
                end
                8'h08: begin
                  // Backspace blanks the cell it retreats onto without moving on.
                  if (col_q != '0) begin
                    col_q      <= col_q - CW'(1);
                    put_char_q <= 8'h20;
                    put_adv_q  <= 1'b0;
                    state_q    <= PUT;
                    o_busy     <= 1'b1;
                  end
                end
                8'h0C: begin
                  col_q   <= '0;
                  row_q   <= '0;
                  clr_q   <= '0;
                  state_q <= CLR_ALL;
                  o_busy  <= 1'b1;
                end
                default: ;
              endcase
            end
          end
        end

        PUT: begin
          o_we   <= 1'b1;
          o_addr <= cur_addr;
          o_char <= put_char_q;
          o_busy <= 1'b1;
          if (!put_adv_q) begin
            state_q <= IDLE;
          end else if (col_q == COL_MAX) begin
            col_q   <= '0;
            row_q   <= row_d;
            clr_q   <= '0;
            state_q <= CLR_ROW;
          end else begin
            col_q   <= col_q + CW'(1);
            state_q <= IDLE;
          end
        end

        CLR_ROW: begin
          o_we   <= 1'b1;
          o_addr <= row_base + clr_q;
          o_char <= 8'h20;
          o_busy <= 1'b1;
          if (clr_q == ROWL_A) state_q <= IDLE;
          else                 clr_q   <= clr_q + ADDR_W'(1);
        end

        CLR_ALL: begin
          o_we   <= 1'b1;
          o_addr <= clr_q;
          o_char <= 8'h20;
          o_busy <= 1'b1;
          if (clr_q == LAST_A) state_q <= IDLE;
          else                 clr_q   <= clr_q + ADDR_W'(1);
        end

        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_text_writer.sv
// Bench for uart_text_writer: directed and random bytes checked against a
// terminal model that predicts the exact sequence of RAM writes.
module tb_uart_text_writer;
  localparam int C  = 80;
  localparam int R  = 30;
  localparam int AW = 12;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_wr;
  logic [7:0]    i_data;
  logic          o_we;
  logic [AW-1:0] o_addr;
  logic [7:0]    o_char;
  logic          o_busy;
  logic          o_overrun;

  uart_text_writer #(.COLS(C), .ROWS(R), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .i_wr(i_wr), .i_data(i_data),
    .o_we(o_we), .o_addr(o_addr), .o_char(o_char),
    .o_busy(o_busy), .o_overrun(o_overrun)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int unsigned cyc = 0;
  int unsigned last_d = 0;
  int obs_a[$], obs_c[$], exp_a[$], exp_c[$];
  int unsigned obs_t[$];
  int ovr_cnt = 0;
  int busy_viol = 0;
  int mr = 0, mc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst) begin
      if (o_we) begin
        obs_a.push_back(int'(o_addr));
        obs_c.push_back(int'(o_char));
        obs_t.push_back(cyc);
        if (!o_busy) busy_viol++;
      end
      if (o_overrun) ovr_cnt++;
    end
  end

  function automatic void push_w(input int a, input int ch);
    exp_a.push_back(a);
    exp_c.push_back(ch);
  endfunction

  function automatic void clear_row(input int r);
    for (int i = 0; i < C; i++) push_w(r * C + i, 32);
  endfunction

  function automatic void model(input logic [7:0] b);
    if (b >= 8'h20 && b <= 8'h7E) begin
      push_w(mr * C + mc, int'(b));
      mc++;
      if (mc == C) begin
        mc = 0;
        mr = (mr + 1) % R;
        clear_row(mr);
      end
    end else if (b == 8'h0D) begin
      mc = 0;
    end else if (b == 8'h0A) begin
      mc = 0;
      mr = (mr + 1) % R;
      clear_row(mr);
    end else if (b == 8'h08) begin
      if (mc > 0) begin
        mc--;
        push_w(mr * C + mc, 32);
      end
    end else if (b == 8'h0C) begin
      mr = 0;
      mc = 0;
      for (int i = 0; i < C * R; i++) push_w(i, 32);
    end
  endfunction

  task automatic pulse(input logic [7:0] b, input int hold);
    @(negedge clk);
    last_d = cyc;
    i_data = b;
    i_wr   = 1'b1;
    repeat (hold) @(negedge clk);
    i_wr = 1'b0;
  endtask

  task automatic send(input logic [7:0] b, input int hold);
    pulse(b, hold);
    model(b);
  endtask

  task automatic wait_quiet(input string tag);
    int q = 0;
    int n = 0;
    while (q < 6 && n < 6000) begin
      @(negedge clk);
      n++;
      q = o_busy ? 0 : q + 1;
    end
    total++;
    assert (q >= 6) else begin
      bad++;
      $error("FAIL %s_timeout observed busy=%0b after %0d cycles, required idle", tag, o_busy, n);
    end
  endtask

  task automatic check_writes(input string tag);
    int n, nm, first;
    total++;
    assert (obs_a.size() === exp_a.size()) else begin
      bad++;
      $error("FAIL %s_count observed=%0d expected=%0d", tag, obs_a.size(), exp_a.size());
    end
    n = (obs_a.size() < exp_a.size()) ? obs_a.size() : exp_a.size();
    nm = 0;
    first = 0;
    for (int i = 0; i < n; i++)
      if (obs_a[i] !== exp_a[i] || obs_c[i] !== exp_c[i]) begin
        if (nm == 0) first = i;
        nm++;
      end
    total++;
    assert (nm === 0) else begin
      bad++;
      $error("FAIL %s_data %0d bad, first #%0d observed=%0d/%02h expected=%0d/%02h",
             tag, nm, first, obs_a[first], obs_c[first], exp_a[first], exp_c[first]);
    end
    obs_a.delete(); obs_c.delete(); obs_t.delete();
    exp_a.delete(); exp_c.delete();
  endtask

  task automatic chk(input string tag, input int obs, input int expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  initial begin
    int unsigned t0, t1;
    int n, k;
    logic [7:0] b;

    rst = 1'b0; i_wr = 1'b0; i_data = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_we", int'(o_we), 0);
    chk("rst_addr", int'(o_addr), 0);
    chk("rst_char", int'(o_char), 0);
    chk("rst_busy", int'(o_busy), 0);
    chk("rst_ovr", int'(o_overrun), 0);
    rst = 1'b1;
    repeat (3) @(negedge clk);

    // single byte, long level: one write, two cycles after the sampling edge
    send(8'h41, 1300);
    wait_quiet("A");
    t0 = (obs_t.size() > 0) ? obs_t[0] : 0;
    chk("A_latency", int'(t0), int'(last_d + 3));
    check_writes("A");

    // full screen clear, contiguous and busy throughout
    busy_viol = 0;
    send(8'h0C, 2);
    wait_quiet("FF");
    t0 = (obs_t.size() > 0) ? obs_t[0] : 0;
    t1 = (obs_t.size() > 0) ? obs_t[obs_t.size() - 1] : 0;
    chk("FF_span", int'(t1 - t0), C * R - 1);
    chk("FF_busy", busy_viol, 0);
    check_writes("FF");

    // fill a row: wrap clears the next row with no gap
    for (int i = 0; i < C; i++) begin
      send(8'($urandom_range(32, 126)), 2);
      wait_quiet("row");
    end
    t0 = (obs_t.size() > 80) ? obs_t[79] : 0;
    t1 = (obs_t.size() > 80) ? obs_t[80] : 0;
    chk("wrap_gap", int'(t1 - t0), 1);
    t0 = (obs_t.size() > 159) ? obs_t[159] : 0;
    chk("wrap_span", int'(t0 - t1), C - 1);
    check_writes("row");

    // cursor to (29,5) then LF wraps to row 0
    for (int i = 0; i < 28; i++) begin send(8'h0A, 1); wait_quiet("lf"); end
    for (int i = 0; i < 5; i++) begin send(8'h61 + 8'(i), 1); wait_quiet("p5"); end
    send(8'h0A, 1); wait_quiet("lfwrap");
    check_writes("lfwrap");

    // backspace mid-row and at column 0
    send(8'h78, 1); wait_quiet("bs");
    send(8'h79, 1); wait_quiet("bs");
    send(8'h78, 1); wait_quiet("bs");
    send(8'h08, 1); wait_quiet("bs");
    send(8'h0D, 1); wait_quiet("bs");
    send(8'h08, 1); wait_quiet("bs");
    send(8'h6B, 1); wait_quiet("bs");
    check_writes("bs");

    // bytes during a clear: first waits, second overruns
    ovr_cnt = 0;
    send(8'h0C, 2);
    repeat (100) @(negedge clk);
    send(8'h42, 3);
    repeat (5) @(negedge clk);
    pulse(8'h43, 3);
    wait_quiet("ovr");
    chk("ovr_pulses", ovr_cnt, 1);
    check_writes("ovr");

    // random traffic
    for (int i = 0; i < 60; i++) begin
      k = int'($urandom_range(0, 19));
      if (k < 10)      b = 8'($urandom_range(32, 126));
      else if (k < 12) b = 8'h0D;
      else if (k < 14) b = 8'h0A;
      else if (k < 17) b = 8'h08;
      else if (k < 18) b = 8'h0C;
      else if (k < 19) b = 8'($urandom_range(0, 31));
      else             b = 8'($urandom_range(127, 255));
      send(b, int'($urandom_range(1, 8)));
      wait_quiet("rand");
    end
    chk("rand_ovr", ovr_cnt, 1);
    check_writes("rand");

    // async reset part way through a full clear
    send(8'h0C, 1);
    n = 0;
    while (obs_a.size() < 1000 && n < 3000) begin @(negedge clk); n++; end
    chk("rst_mid_reach", (obs_a.size() >= 1000) ? 1 : 0, 1);
    #1 rst = 1'b0;
    #1;
    chk("rst_mid_we", int'(o_we), 0);
    chk("rst_mid_busy", int'(o_busy), 0);
    obs_a.delete(); obs_c.delete(); obs_t.delete();
    exp_a.delete(); exp_c.delete();
    mr = 0; mc = 0;
    i_data = 8'h51; i_wr = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (20) @(negedge clk);
    i_wr = 1'b0;
    repeat (5) @(negedge clk);
    chk("wr_at_release", obs_a.size(), 0);

    // ignored control byte leaves the cursor in place
    send(8'h61, 1); wait_quiet("bel");
    send(8'h07, 1); wait_quiet("bel");
    send(8'h62, 1); wait_quiet("bel");
    check_writes("bel");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #20_000_000;
    bad++;
    $display("FAIL global_timeout observed=running required=finished");
    $fatal(1, "test done: total=%0d bad=%0d", total, bad);
  end
endmodule
